// File: rtl/snap_pkg.sv
// Shared definitions for the ADC snapshot capture path: FSM encoding and
// bit positions inside the control and status words.
package snap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int ARM_BIT      = 0;
    localparam int TRIG_SEL_BIT = 1;
    localparam int WE_SEL_BIT   = 2;
    localparam int DELAY_LSB    = 16;
    localparam int DELAY_MSB    = 31;

    localparam int DONE_BIT     = 31;
    localparam int BUSY_BIT     = 30;

endpackage

// File: rtl/adcsnap_capture_ctrl.sv
// Snapshot capture sequencer: arms on a rising arm bit, waits for a trigger and
// optional delay, then writes one full BRAM depth of ADC samples.
module adcsnap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic [31:0]       status_word
);

    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    state_t          state;
    logic [31:0]     ctrl_q;
    logic            arm_q_d;
    logic            trig_sel_r;
    logic [15:0]     delay_r;
    logic [15:0]     delay_cnt;
    logic [ADDR_W:0] count;

    logic arm_pulse;
    logic qs;
    logic trigger;

    assign arm_pulse = ctrl_q[ARM_BIT] & ~arm_q_d;
    assign qs        = ~ctrl_q[WE_SEL_BIT] | din_valid;
    assign trigger   = ~trig_sel_r | trig_in;

    // Control bits 15:3 are reserved; reducing them keeps them visibly accounted for.
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_q[DELAY_LSB-1:WE_SEL_BIT+1];

    // NOTE: every register here, including the BRAM-side outputs, is reset so that
    // a reset in any state yields all-zero outputs on the following cycle.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state      <= ST_IDLE;
            ctrl_q     <= '0;
            arm_q_d    <= 1'b0;
            trig_sel_r <= 1'b0;
            delay_r    <= '0;
            delay_cnt  <= '0;
            count      <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            bram_we    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees
            // the pre-edge values of the others regardless of statement order.
            ctrl_q  <= ctrl_word;
            arm_q_d <= ctrl_q[ARM_BIT];
            bram_we <= 1'b0;

            if (arm_pulse) begin
                state      <= ST_ARMED;
                count      <= '0;
                delay_cnt  <= '0;
                trig_sel_r <= ctrl_q[TRIG_SEL_BIT];
                delay_r    <= ctrl_q[DELAY_MSB:DELAY_LSB];
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (trigger) begin
                            if (delay_r != 16'd0) begin
                                state     <= ST_DELAY;
                                delay_cnt <= delay_r;
                            end else begin
                                state <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        // The sample that brings the counter to zero is skipped, not written.
                        if (qs) begin
                            delay_cnt <= delay_cnt - 16'd1;
                            if (delay_cnt == 16'd1) begin
                                state <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (qs) begin
                            bram_we   <= 1'b1;
                            bram_addr <= count[ADDR_W-1:0];
                            bram_din  <= din;
                            count     <= count + 1'b1;
                            if (count == LAST_CNT) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: default assignment first so no status bit can infer a latch.
    always_comb begin
        status_word             = '0;
        status_word[DONE_BIT]   = (state == ST_DONE);
        status_word[BUSY_BIT]   = (state == ST_ARMED) || (state == ST_DELAY) ||
                                  (state == ST_CAPTURE);
        status_word[ADDR_W:0]   = count;
    end

endmodule

// File: tb/tb_adcsnap_capture_ctrl.sv
// Directed testbench for adcsnap_capture_ctrl with a 16-deep capture buffer.
module tb_adcsnap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 64;

    localparam logic [31:0] ST_DONE_FULL = 32'h8000_0010;
    localparam logic [31:0] ST_BUSY_ZERO = 32'h4000_0000;

    logic              user_clk = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [31:0]       ctrl_word = '0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              trig_in = 1'b0;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [31:0]       status_word;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] s_din;
    logic              s_valid;

    adcsnap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .ctrl_word   (ctrl_word),
        .din         (din),
        .din_valid   (din_valid),
        .trig_in     (trig_in),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .status_word (status_word)
    );

    always #5 user_clk = ~user_clk;

    // Advance one edge; remember the inputs that edge sampled, then step din.
    task automatic tick();
        @(posedge user_clk);
        #1;
        s_din   = din;
        s_valid = din_valid;
        din     = din + 1;
    endtask

    task automatic do_reset();
        ctrl_word  = '0;
        trig_in    = 1'b0;
        din_valid  = 1'b0;
        user_rst_n = 1'b0;
        tick();
        tick();
        user_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0;
        ctrl_word  = 32'h1;
        tick();
        tick();
        checks++;
        if (status_word !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", status_word, 32'h0);
        end
        checks++;
        if (bram_we !== 1'b0) begin
            errors++; $display("FAIL reset_we: got %b expected 0", bram_we);
        end
        checks++;
        if (bram_addr !== '0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0", bram_addr);
        end
        checks++;
        if (bram_din !== '0) begin
            errors++; $display("FAIL reset_din: got %h expected 0", bram_din);
        end
    endtask

    task automatic test_immediate();
        do_reset();
        ctrl_word = 32'h1;
        for (int e = 1; e <= 22; e++) begin
            logic exp_we;
            tick();
            exp_we = (e >= 4) && (e <= 19);
            checks++;
            if (bram_we !== exp_we) begin
                errors++; $display("FAIL imm_we edge %0d: got %b expected %b", e, bram_we, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (bram_addr !== ADDR_W'(e - 4)) begin
                    errors++; $display("FAIL imm_addr edge %0d: got %0d expected %0d", e, bram_addr, e - 4);
                end
                checks++;
                if (bram_din !== s_din) begin
                    errors++; $display("FAIL imm_din edge %0d: got %h expected %h", e, bram_din, s_din);
                end
            end
            if (e == 2) begin
                checks++;
                if (status_word !== ST_BUSY_ZERO) begin
                    errors++; $display("FAIL imm_armed_status: got %h expected %h", status_word, ST_BUSY_ZERO);
                end
            end
            if (e == 19 || e == 22) begin
                checks++;
                if (status_word !== ST_DONE_FULL) begin
                    errors++; $display("FAIL imm_done_status edge %0d: got %h expected %h", e, status_word, ST_DONE_FULL);
                end
            end
        end
    endtask

    task automatic test_ext_trigger_delay();
        logic [DATA_W-1:0] trig_din;
        do_reset();
        ctrl_word = 32'h0003_0003;
        tick();
        tick();
        checks++;
        if (status_word !== ST_BUSY_ZERO) begin
            errors++; $display("FAIL ext_armed_status: got %h expected %h", status_word, ST_BUSY_ZERO);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0 || status_word !== ST_BUSY_ZERO) begin
                errors++; $display("FAIL ext_pretrig %0d: got we %b status %h expected we 0 status %h", i, bram_we, status_word, ST_BUSY_ZERO);
            end
        end
        trig_in = 1'b1;
        tick();
        trig_din = s_din;
        trig_in  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0) begin
                errors++; $display("FAIL ext_delay_we %0d: got %b expected 0", i, bram_we);
            end
        end
        for (int n = 0; n < 16; n++) begin
            tick();
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(n)) begin
                errors++; $display("FAIL ext_write %0d: got we %b addr %0d expected we 1 addr %0d", n, bram_we, bram_addr, n);
            end
            if (n == 0) begin
                checks++;
                if (bram_din !== trig_din + 4) begin
                    errors++; $display("FAIL ext_first_sample: got %h expected %h", bram_din, trig_din + 4);
                end
            end
        end
        checks++;
        if (status_word !== ST_DONE_FULL) begin
            errors++; $display("FAIL ext_done_status: got %h expected %h", status_word, ST_DONE_FULL);
        end
    endtask

    task automatic test_valid_gated();
        int n;
        do_reset();
        ctrl_word = 32'h5;
        tick();
        tick();
        tick();
        n = 0;
        for (int e = 4; e <= 35; e++) begin
            din_valid = (e % 2 == 0);
            tick();
            checks++;
            if (bram_we !== s_valid) begin
                errors++; $display("FAIL vg_we edge %0d: got %b expected %b", e, bram_we, s_valid);
            end
            if (s_valid) begin
                checks++;
                if (bram_addr !== ADDR_W'(n) || bram_din !== s_din) begin
                    errors++; $display("FAIL vg_write %0d: got addr %0d din %h expected addr %0d din %h", n, bram_addr, bram_din, n, s_din);
                end
                n++;
            end
            checks++;
            if (status_word[ADDR_W:0] !== (ADDR_W+1)'(n)) begin
                errors++; $display("FAIL vg_count edge %0d: got %0d expected %0d", e, status_word[ADDR_W:0], n);
            end
        end
        din_valid = 1'b0;
        checks++;
        if (status_word !== ST_DONE_FULL) begin
            errors++; $display("FAIL vg_done_status: got %h expected %h", status_word, ST_DONE_FULL);
        end
    endtask

    task automatic test_rearm();
        logic saw_done;
        saw_done = 1'b0;
        do_reset();
        ctrl_word = 32'h1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            saw_done |= status_word[31];
        end
        checks++;
        if (status_word !== 32'h4000_0007) begin
            errors++; $display("FAIL rearm_seven: got %h expected %h", status_word, 32'h4000_0007);
        end
        ctrl_word = 32'h0;
        tick();
        saw_done |= status_word[31];
        ctrl_word = 32'h1;
        tick();
        saw_done |= status_word[31];
        tick();
        saw_done |= status_word[31];
        checks++;
        if (status_word !== ST_BUSY_ZERO || bram_we !== 1'b0) begin
            errors++; $display("FAIL rearm_cleared: got status %h we %b expected status %h we 0", status_word, bram_we, ST_BUSY_ZERO);
        end
        tick();
        saw_done |= status_word[31];
        tick();
        saw_done |= status_word[31];
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== '0) begin
            errors++; $display("FAIL rearm_restart: got we %b addr %0d expected we 1 addr 0", bram_we, bram_addr);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL rearm_no_done: got %b expected 0", saw_done);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checks++;
        if (status_word !== ST_DONE_FULL) begin
            errors++; $display("FAIL rearm_done_status: got %h expected %h", status_word, ST_DONE_FULL);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        ctrl_word = 32'h1;
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
        checks++;
        if (status_word !== 32'h4000_0005) begin
            errors++; $display("FAIL rstmid_five: got %h expected %h", status_word, 32'h4000_0005);
        end
        user_rst_n = 1'b0;
        ctrl_word  = 32'h0;
        tick();
        checks++;
        if (status_word !== 32'h0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got status %h we %b addr %0d din %h expected all 0", status_word, bram_we, bram_addr, bram_din);
        end
        user_rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bram_we !== 1'b0 || status_word !== 32'h0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rstmid_idle: got %0d active cycles expected 0", stray);
        end
        ctrl_word = 32'h1;
        for (int e = 1; e <= 4; e++) begin
            tick();
        end
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== '0) begin
            errors++; $display("FAIL rstmid_rearm: got we %b addr %0d expected we 1 addr 0", bram_we, bram_addr);
        end
    endtask

    task automatic test_ignored();
        int stray;
        do_reset();
        trig_in = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bram_we !== 1'b0 || status_word !== 32'h0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL ign_idle_trig: got %0d active cycles expected 0", stray);
        end
        trig_in   = 1'b0;
        ctrl_word = 32'h1;
        for (int e = 1; e <= 19; e++) begin
            tick();
        end
        checks++;
        if (status_word !== ST_DONE_FULL) begin
            errors++; $display("FAIL ign_first_done: got %h expected %h", status_word, ST_DONE_FULL);
        end
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            trig_in = i[0];
            tick();
            if (bram_we !== 1'b0 || status_word !== ST_DONE_FULL) stray++;
        end
        trig_in = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL ign_arm_held: got %0d deviating cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_ext_trigger_delay();
        test_valid_gated();
        test_rearm();
        test_reset_mid();
        test_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
